// File: rtl/decode_div_pkg.sv
// Shared types and constants for the sequential 61s/22s -> 40s decode divider.
// Saturation bounds are fixed to the default quotient width used by the decode path.
package decode_div_pkg;

  localparam int DIN0_W = 61;
  localparam int DIN1_W = 22;
  localparam int DOUT_W = 40;

  // One count value per dividend bit, plus headroom for the terminal value
  localparam int CNT_W = $clog2(DIN0_W + 1);

  localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/decode_div_signfix.sv
// Turns the unsigned quotient/remainder magnitudes into signed, saturated results,
// with the zero-divisor override taking priority over everything else.
module decode_div_signfix
  import decode_div_pkg::*;
#(
  parameter int N_W = DIN0_W,
  parameter int D_W = DIN1_W,
  parameter int Q_W = DOUT_W
) (
  input  logic [N_W-1:0] q_mag,
  input  logic [D_W-1:0] r_mag,
  input  logic           sign_n,
  input  logic           sign_d,
  input  logic           zero_d,
  output logic [Q_W-1:0] quot,
  output logic [D_W-1:0] rem,
  output logic           ovf
);

  // Largest magnitudes representable for a positive / negative quotient
  localparam logic [N_W-1:0] POS_LIMIT = N_W'(QMAX);
  localparam logic [N_W-1:0] NEG_LIMIT = N_W'(QMIN);

  logic sign_q;

  assign sign_q = sign_n ^ sign_d;

  always_comb begin
    quot = '0;
    rem  = '0;
    ovf  = 1'b0;
    if (zero_d) begin
      quot = sign_n ? QMIN : QMAX;
    end else begin
      rem = sign_n ? -r_mag : r_mag;
      if (!sign_q) begin
        if (q_mag > POS_LIMIT) begin
          quot = QMAX;
          ovf  = 1'b1;
        end else begin
          quot = q_mag[Q_W-1:0];
        end
      end else begin
        // A magnitude of exactly 2^(Q_W-1) negates onto itself, which is QMIN
        if (q_mag > NEG_LIMIT) begin
          quot = QMIN;
          ovf  = 1'b1;
        end else begin
          quot = -q_mag[Q_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/decode_div_61s_22s_40_seq.sv
// Radix-2 restoring signed divider, one quotient bit per enabled cycle, fixed latency
// of din0_WIDTH+2 enabled cycles from accepted start to the done pulse.
module decode_div_61s_22s_40_seq
  import decode_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div0,
  output logic                  ovf
);

  localparam int id_unused = ID;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(din0_WIDTH - 1);

  state_t state, next_state;

  logic [CNT_W-1:0]      count;
  logic [din0_WIDTH-1:0] shreg;
  logic [din1_WIDTH-1:0] prem;
  logic [din1_WIDTH-1:0] div_mag;
  logic                  sign_n;
  logic                  sign_d;
  logic                  zero_d;

  logic [din0_WIDTH-1:0] din0_mag;
  logic [din1_WIDTH-1:0] din1_mag;
  logic [din1_WIDTH:0]   shifted;
  logic [din1_WIDTH:0]   diff;
  logic                  qbit;

  logic [dout_WIDTH-1:0] fix_quot;
  logic [din1_WIDTH-1:0] fix_rem;
  logic                  fix_ovf;

  assign din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
  assign din1_mag = din1[din1_WIDTH-1] ? -din1 : din1;

  // shreg starts as the dividend magnitude and fills with quotient bits from the right
  assign shifted = {prem, shreg[din0_WIDTH-1]};
  assign diff    = shifted - {1'b0, div_mag};
  assign qbit    = ~diff[din1_WIDTH];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !busy) next_state = CALC;
      CALC:    if (count == LAST_BIT) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  decode_div_signfix #(
    .N_W (din0_WIDTH),
    .D_W (din1_WIDTH),
    .Q_W (dout_WIDTH)
  ) u_signfix (
    .q_mag  (shreg),
    .r_mag  (prem),
    .sign_n (sign_n),
    .sign_d (sign_d),
    .zero_d (zero_d),
    .quot   (fix_quot),
    .rem    (fix_rem),
    .ovf    (fix_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      shreg   <= '0;
      prem    <= '0;
      div_mag <= '0;
      sign_n  <= 1'b0;
      sign_d  <= 1'b0;
      zero_d  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      rem     <= '0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else if (ce) begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // busy still high in IDLE means this is the done cycle; retire it
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy    <= 1'b1;
            shreg   <= din0_mag;
            div_mag <= din1_mag;
            sign_n  <= din0[din0_WIDTH-1];
            sign_d  <= din1[din1_WIDTH-1];
            zero_d  <= (din1 == '0);
            prem    <= '0;
            count   <= '0;
          end
        end
        CALC: begin
          prem  <= qbit ? diff[din1_WIDTH-1:0] : shifted[din1_WIDTH-1:0];
          shreg <= {shreg[din0_WIDTH-2:0], qbit};
          count <= count + CNT_W'(1);
        end
        FIX: begin
          dout <= fix_quot;
          rem  <= fix_rem;
          ovf  <= fix_ovf;
          div0 <= zero_d;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
